pipe_mem_arbiter: RTL

PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

---
 rtl/pipe_mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - single-port memory arbiter between pipeline fetch and load/store
// Ports:
//   clock, resetn                      clock and async active-low reset
//   if_req, if_addr -> if_ack, if_rdata    instruction fetch requester
//   m_rd, m_wr, m_addr, m_wdata -> m_ack, m_rdata   MEM-stage load/store requester
//   mem_req, mem_we, mem_addr, mem_wdata <- mem_ready, mem_rdata   shared memory port
//   stall_if, stall_m                  pipeline freeze requests
//   err                                sticky protocol/timeout error
module pipe_mem_arbiter (
  input  logic        clock,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        m_rd,
  input  logic        m_wr,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        m_ack,
  output logic [31:0] m_rdata,
  output logic        stall_if,
  output logic        stall_m,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  starve_cnt_q, starve_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        if_ack_q, if_ack_d;
  logic        m_ack_q, m_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] m_rdata_q, m_rdata_d;
  logic        err_q, err_d;

  logic m_any;
  logic fetch_turn;

  assign m_any = m_rd | m_wr;
  // After three back-to-back data wins over a waiting fetch, the fetch gets the next slot.
  assign fetch_turn = if_req & (starve_cnt_q == 2'd3);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    if_ack_d     = 1'b0;
    m_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    m_rdata_d    = m_rdata_q;
    // Simultaneous read and write is serviced as a store but flagged.
    err_d        = err_q | (m_rd & m_wr);
    case (state_q)
      IDLE: begin
        if (m_any && !fetch_turn) begin
          state_d    = DATA;
          wait_cnt_d = 4'd0;
          if (if_req && starve_cnt_q != 2'd3) starve_cnt_d = starve_cnt_q + 2'd1;
        end else if (if_req) begin
          state_d      = FETCH;
          wait_cnt_d   = 4'd0;
          starve_cnt_d = 2'd0;
        end
      end
      DATA, FETCH: begin
        if (mem_ready) begin
          state_d = IDLE;
          if (state_q == DATA) begin
            m_ack_d = 1'b1;
            if (m_rd && !m_wr) m_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          if (wait_cnt_q != 4'd15) wait_cnt_d = wait_cnt_q + 4'd1;
          // Flag as soon as the counter reaches 15; the access keeps waiting regardless.
          if (wait_cnt_q >= 4'd14) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      starve_cnt_q <= 2'd0;
      wait_cnt_q   <= 4'd0;
      if_ack_q     <= 1'b0;
      m_ack_q      <= 1'b0;
      if_rdata_q   <= 32'd0;
      m_rdata_q    <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      if_ack_q     <= if_ack_d;
      m_ack_q      <= m_ack_d;
      if_rdata_q   <= if_rdata_d;
      m_rdata_q    <= m_rdata_d;
      err_q        <= err_d;
    end
  end

  // Memory port is driven straight from state so the address appears in the entry cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state_q)
      DATA: begin
        mem_req   = 1'b1;
        mem_we    = m_wr;
        mem_addr  = m_addr;
        mem_wdata = m_wdata;
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
      end
      default: ;
    endcase
  end

  assign if_ack   = if_ack_q;
  assign m_ack    = m_ack_q;
  assign if_rdata = if_rdata_q;
  assign m_rdata  = m_rdata_q;
  assign err      = err_q;
  assign stall_m  = m_any & ~m_ack_q;
  assign stall_if = stall_m | (if_req & ~if_ack_q);

endmodule
